memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single cache-to-memory line bus between `PORTS` cache requesters, e.g. instruction cache and data cache. Each requester issues full-line reads (refills) or full-line writes (write-backs). The arbiter grants one requester at a time, drives the memory bus for that requester, and routes `ready`/`done` back to it. It sits between the cache instances and the memory model/controller. Only one memory transaction is ever outstanding.

## Interface
Parameters:
- `XLEN`, 32, word width in bits
- `WORDS`, 4, words per cache line; line = `WORDS*XLEN` bits
- `PORTS`, 2, number of requesters (≥2); port 0 = instruction cache, port 1 = data cache

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_read`  in  PORTS  per-port line-read request; held until `req_ready[p]`
- `req_write`  in  PORTS  per-port line-write request; held until `req_done[p]`
- `req_address`  in  PORTS*XLEN  per-port line address; bits [log2(WORDS)+1:0] ignored
- `req_wdata`  in  PORTS*WORDS*XLEN  per-port write line
- `req_rdata`  out  WORDS*XLEN  shared read line; valid only with a `req_ready` bit
- `req_ready`  out  PORTS  one-cycle pulse: read line delivered to port p
- `req_done`  out  PORTS  one-cycle pulse: write accepted for port p
- `grant`  out  PORTS  one-hot current owner; 0 when idle
- `busy`  out  1  transaction in flight
- `mem_read`, `mem_write`  out  1  memory request strobes, held until `mem_ready`/`mem_done`
- `mem_address`  out  XLEN  line-aligned address; low log2(WORDS)+2 bits forced to 0
- `mem_wdata`  out  WORDS*XLEN  write line
- `mem_rdata`  in  WORDS*XLEN  read line; valid with `mem_ready`
- `mem_ready`, `mem_done`  in  1  memory read-complete / write-complete, single cycle

## Operation
- FSM states and transitions:
  - IDLE → READ or WRITE on a winning request.
  - READ → RESP on `mem_ready`.
  - WRITE → RESP on `mem_done`.
  - RESP → IDLE unconditionally.
- IDLE arbitration:
  - Round-robin pointer `last`. Search starts at port `(last+1) mod PORTS`.
  - The first port with `req_read|req_write` wins, and `last` becomes the winner.
  - Within one port, a write beats a read, so a write-back precedes a refill.
- On grant:
  - Latch address, line-aligned, plus wdata for writes.
  - Set `grant`, `busy`, and `mem_read` or `mem_write`.
  - Requester input changes after grant are ignored.
- READ/WRITE: hold the strobe, address and data stable until completion.
  - In READ, latch `mem_rdata` into `req_rdata` on `mem_ready`.
  - `mem_done` in READ and `mem_ready` in WRITE are ignored.
- RESP:
  - Strobe is low.
  - Pulse `req_ready[p]` (read) or `req_done[p]` (write).
  - No arbitration this cycle. The requester drops its request, so a stale request is never re-granted.
- A requester dropping its request mid-transaction does not abort it: the memory access completes and the response pulse is still issued.
- No memory timeout. A memory that never responds holds the bus indefinitely.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State becomes IDLE and all outputs go to 0, including `req_rdata` and `mem_address`.
  - `last` is set to PORTS-1, so port 0 has first priority.
  - Reset mid-transaction drops the transaction silently; no response pulse.
- Request seen in IDLE at edge N → `grant`/`busy`/strobe high after edge N+1.
- `mem_ready`/`mem_done` high at edge K:
  - Strobe low and `req_ready`/`req_done` high after edge K+1 (RESP).
  - IDLE after K+2.
- Minimum read turnaround with zero-wait memory is 3 cycles. Back-to-back grants are separated by exactly 1 RESP cycle.
- `busy` is high in READ, WRITE and RESP.
- `grant` stays high through RESP.

## Configuration
- `MEM_ARB_WRITE_PRIO_EN` defined:
  - Any pending write on any port beats every read.
  - Round-robin applies among writers, then among readers.
  - `last` updates on every grant.
- Not defined: pure port round-robin as described above; per-port write-over-read still applies.

## Test plan
- Single read, port 0, addr 0x0000_1234:
  - `mem_address`=0x0000_1230 one cycle after the request.
  - Memory returns a line with `mem_ready` 2 cycles later.
  - `req_ready`=2'b01 pulse with `req_rdata` equal to that line.
  - `busy` low 1 cycle later.
- Both ports read continuously from reset:
  - Grants alternate 01,10,01,10.
  - Each grant is separated by exactly one RESP cycle; no port is granted twice in a row.
- Port 1 asserts read and write together (wdata 0xA5 pattern):
  - Write serviced first with `req_done`=2'b10.
  - Then the read with `req_ready`=2'b10.
- Reset low while `mem_read` is high waiting for memory:
  - All outputs 0 immediately, with no `req_ready` pulse.
  - After release, port 0 wins a simultaneous port 0/port 1 request.
- With `MEM_ARB_WRITE_PRIO_EN`: `last`=0, port 1 reads while port 0 writes → port 0 write granted first. Without the macro → port 1 read granted first.
- Port 0 drops `req_read` one cycle after grant, and address/wdata inputs toggle:
  - `mem_address` remains stable.
  - `req_ready[0]` still pulses after `mem_ready`.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one line-wide memory bus among PORTS cache requesters.
// Define MEM_ARB_WRITE_PRIO_EN to let any pending write beat every read.
module memory_arbiter #(
  parameter int XLEN  = 32,
  parameter int WORDS = 4,
  parameter int PORTS = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PORTS-1:0]            req_read,
  input  logic [PORTS-1:0]            req_write,
  input  logic [PORTS*XLEN-1:0]       req_address,
  input  logic [PORTS*WORDS*XLEN-1:0] req_wdata,
  output logic [WORDS*XLEN-1:0]       req_rdata,
  output logic [PORTS-1:0]            req_ready,
  output logic [PORTS-1:0]            req_done,
  output logic [PORTS-1:0]            grant,
  output logic                        busy,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [XLEN-1:0]             mem_address,
  output logic [WORDS*XLEN-1:0]       mem_wdata,
  input  logic [WORDS*XLEN-1:0]       mem_rdata,
  input  logic                        mem_ready,
  input  logic                        mem_done
);
  localparam int LW = WORDS*XLEN;
  localparam int AB = $clog2(WORDS)+2;
  localparam int PW = $clog2(PORTS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     last_q, last_d, owner_q, owner_d, win;
  logic              wr_q, wr_d, found, win_wr;
  logic [XLEN-1:0]   addr_q, addr_d, sel_addr;
  logic [LW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [PORTS-1:0]  owner_oh;

  function automatic logic [PW-1:0] rr(input logic [PW-1:0] l, input int i);
    return PW'((int'(l) + i) % PORTS);
  endfunction

  // Search starts just after the last winner; write beats read within a port.
  always_comb begin
    found  = 1'b0;
    win    = last_q;
    win_wr = 1'b0;
`ifdef MEM_ARB_WRITE_PRIO_EN
    for (int i = 1; i <= PORTS; i++)
      if (!found && req_write[rr(last_q, i)]) begin
        found  = 1'b1;
        win    = rr(last_q, i);
        win_wr = 1'b1;
      end
`endif
    for (int i = 1; i <= PORTS; i++)
      if (!found && (req_read[rr(last_q, i)] || req_write[rr(last_q, i)])) begin
        found  = 1'b1;
        win    = rr(last_q, i);
        win_wr = req_write[rr(last_q, i)];
      end
    sel_addr = req_address[int'(win)*XLEN +: XLEN];
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = win_wr ? WRITE : READ;
        last_d  = win;
        owner_d = win;
        wr_d    = win_wr;
        addr_d  = sel_addr & ~{{(XLEN-AB){1'b0}}, {AB{1'b1}}};
        wdata_d = win_wr ? req_wdata[int'(win)*LW +: LW] : wdata_q;
      end
      READ: if (mem_ready) begin
        state_d = RESP;
        rdata_d = mem_rdata;
      end
      WRITE:   state_d = mem_done ? RESP : WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= PW'(PORTS-1);
      owner_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign owner_oh    = {{(PORTS-1){1'b0}}, 1'b1} << owner_q;
  assign busy        = state_q != IDLE;
  assign grant       = busy ? owner_oh : '0;
  assign mem_read    = state_q == READ;
  assign mem_write   = state_q == WRITE;
  assign req_ready   = (state_q == RESP && !wr_q) ? owner_oh : '0;
  assign req_done    = (state_q == RESP && wr_q) ? owner_oh : '0;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = rdata_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;
  localparam int P  = 2;
  localparam int X  = 32;
  localparam int LW = 128;

  logic            clock = 1'b0, reset = 1'b0;
  logic [P-1:0]    req_read = '0, req_write = '0;
  logic [P*X-1:0]  req_address = '0;
  logic [P*LW-1:0] req_wdata = '0;
  logic [LW-1:0]   req_rdata, mem_wdata, mem_rdata = '0;
  logic [P-1:0]    req_ready, req_done, grant;
  logic            busy, mem_read, mem_write, mem_ready = 1'b0, mem_done = 1'b0;
  logic [X-1:0]    mem_address;

  int errors = 0, checks = 0, m_last = P-1;

  memory_arbiter #(.XLEN(X), .WORDS(4), .PORTS(P)) dut (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .req_ready(req_ready), .req_done(req_done), .grant(grant), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_done(mem_done));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
    chk({tag, "_resp"}, {req_ready, req_done}, 0);
  endtask

  // Spec-level choice of the next owner from the currently driven requests.
  function automatic void pick(output int w, output bit wr);
    w = -1;
    wr = 1'b0;
`ifdef MEM_ARB_WRITE_PRIO_EN
    for (int i = 1; i <= P; i++) begin
      int p = (m_last + i) % P;
      if (w < 0 && req_write[p]) begin w = p; wr = 1'b1; end
    end
`endif
    for (int i = 1; i <= P; i++) begin
      int p = (m_last + i) % P;
      if (w < 0 && (req_read[p] || req_write[p])) begin w = p; wr = req_write[p]; end
    end
  endfunction

  // One full transaction from IDLE: grant, lat wait cycles, response, back to IDLE.
  task automatic serve(input int lat, input bit drop);
    int w;
    bit wr;
    logic [X-1:0]  ea;
    logic [LW-1:0] ed, rd;
    logic [P-1:0]  eg;
    pick(w, wr);
    if (w < 0) begin
      checks++;
      errors++;
      $error("FAIL serve_no_request observed=none expected=pending");
      return;
    end
    eg = 2'b01 << w;
    ea = req_address[w*X +: X] & 32'hFFFF_FFF0;
    ed = req_wdata[w*LW +: LW];
    step();
    chk("grant", grant, eg);
    chk("busy", busy, 1);
    chk("strobe", {mem_read, mem_write}, {!wr, wr});
    chk("mem_address", mem_address, ea);
    if (wr) chk("mem_wdata", mem_wdata, ed);
    m_last = w;
    if (drop) begin
      if (wr) req_write[w] = 1'b0; else req_read[w] = 1'b0;
    end
    for (int c = 0; c < lat; c++) begin
      req_address = {$urandom, $urandom};
      req_wdata   = {rnd_line(), rnd_line()};
      if (wr) mem_ready = 1'($urandom); else mem_done = 1'($urandom);
      step();
      mem_ready = 1'b0;
      mem_done  = 1'b0;
      chk("held_strobe", {mem_read, mem_write}, {!wr, wr});
      chk("held_address", mem_address, ea);
      chk("held_grant", grant, eg);
      if (wr) chk("held_wdata", mem_wdata, ed);
    end
    rd = rnd_line();
    mem_rdata = rd;
    if (wr) mem_done = 1'b1; else mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    mem_rdata = rnd_line();
    chk("resp_ready", req_ready, wr ? 2'b00 : eg);
    chk("resp_done", req_done, wr ? eg : 2'b00);
    chk("resp_strobe", {mem_read, mem_write}, 0);
    chk("resp_grant", grant, eg);
    chk("resp_busy", busy, 1);
    if (!wr) chk("resp_rdata", req_rdata, rd);
    if (wr) req_write[w] = 1'b0; else req_read[w] = 1'b0;
    step();
    chk_quiet("idle");
  endtask

  initial begin
    step();
    step();
    chk_quiet("reset");
    chk("reset_addr", mem_address, 0);
    chk("reset_rdata", req_rdata, 0);
    chk("reset_wdata", mem_wdata, 0);
    reset = 1'b1;
    step();
    chk_quiet("release");

    req_address[31:0] = 32'h0000_1234;
    req_read = 2'b01;
    serve(1, 1'b0);

    req_read = 2'b01;
    step();
    chk("pre_abort_read", mem_read, 1);
    #2 reset = 1'b0;
    #1;
    chk_quiet("abort");
    chk("abort_addr", mem_address, 0);
    chk("abort_rdata", req_rdata, 0);
    step();
    chk("abort_no_ready", req_ready, 0);
    reset = 1'b1;
    m_last = P-1;
    req_read = 2'b11;
    for (int n = 0; n < 4; n++) begin
      serve(n % 2, 1'b0);
      req_read = 2'b11;
    end
    req_read = 2'b00;

    req_read  = 2'b10;
    req_write = 2'b10;
    req_wdata[255:128] = {16{8'hA5}};
    serve(0, 1'b0);
    serve(2, 1'b0);

    req_read = 2'b01;
    serve(0, 1'b0);
    req_read  = 2'b10;
    req_write = 2'b01;
    serve(1, 1'b0);
    serve(1, 1'b0);

    req_read = 2'b01;
    serve(3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < P; p++)
        if (!req_read[p] && !req_write[p] && $urandom_range(0, 2) != 0) begin
          req_read[p]  = 1'($urandom);
          req_write[p] = 1'($urandom);
        end
      if (req_read == 0 && req_write == 0) req_read[$urandom_range(0, P-1)] = 1'b1;
      serve($urandom_range(0, 3), 1'($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
